fwuart_rx_cfg: RTL

- Parametrised successor to the fixed 8N1 UART receiver.
- Oversamples `rx` using the shared 16x-baud strobe `clock_x16` and presents received characters on a ready/valid output.
- Adds run-time selection of data width, parity and stop bits, plus parity, framing and overrun error reporting.
- Sits between the pad-side `rx` line and the rv_data_in consumer; one instance per UART channel.

---
 rtl/fwuart_rx_pkg.sv | 37 +++
 rtl/fwuart_rx_sync.sv | 43 ++++
 rtl/fwuart_rx_cfg.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwuart_rx_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package fwuart_rx_pkg;

  // Receiver frame-level states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP1     = 3'd4,
    ST_STOP2     = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } fwuart_rx_state_e;

  // Bit-centre sample point and oversampling ratio.
  localparam int SAMPLE_TICK   = 7;
  localparam int TICKS_PER_BIT = 16;
  // Widest character the parity helper can cover.
  localparam int PAR_W         = 9;

  // Expected parity bit: XOR of the low nbits of data, inverted for odd parity.
  function automatic logic parity_calc(input logic [PAR_W-1:0] data,
                                       input logic [3:0]       nbits,
                                       input logic             odd);
    logic p;
    p = odd;
    for (int i = 0; i < PAR_W; i++) begin
      if (4'(i) < nbits) begin
        p = p ^ data[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fwuart_rx_sync.sv
// Input synchroniser for the serial line. Flops reset to the idle level (1)
// so that reset release never looks like a start bit. o_fall flags a 1->0
// change relative to the value seen on the previous enable (16x strobe).
module fwuart_rx_sync
  import fwuart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_rx,
  input  logic i_en,
  output logic o_rx,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw line through the synchroniser chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
    end
  end

  // Remember the synchronised level as seen on the last strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b1;
    end else if (i_en) begin
      r_prev <= o_rx;
    end else begin
      r_prev <= r_prev;
    end
  end

  assign o_rx   = r_sync[SYNC_STAGES-1];
  assign o_fall = i_en & r_prev & ~o_rx;

endmodule

// File: rtl/fwuart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling, run-time data width,
// parity and stop-bit selection, parity/framing/overrun error pulses and a
// ready/valid character output.
// Optional build macro FWUART_RX_BREAK_DETECT_EN adds a break_det output and
// swallows all-zero frames with a low first stop bit instead of delivering them.
module fwuart_rx_cfg
  import fwuart_rx_pkg::*;
#(
  parameter int MAX_DATA_BITS = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clock_x16,
  input  logic                     rx,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_stop2,
  output logic [MAX_DATA_BITS-1:0] i_dat,
  output logic                     i_valid,
  input  logic                     i_ready,
  output logic                     parity_err,
  output logic                     framing_err,
  output logic                     overrun_err,
  output logic                     busy
`ifdef FWUART_RX_BREAK_DETECT_EN
  ,output logic                    break_det
`endif
);

  fwuart_rx_state_e r_state, w_state_nxt;

  logic                               w_rx;
  logic                               w_fall;
  logic [$clog2(TICKS_PER_BIT)-1:0]   r_tick;
  logic [3:0]                         r_bit_cnt;
  logic [3:0]                         r_cfg_bits;
  logic                               r_cfg_par_en;
  logic                               r_cfg_par_odd;
  logic                               r_cfg_stop2;
  logic [MAX_DATA_BITS-1:0]           r_data;
  logic                               r_par_err;
  logic [3:0]                         w_cfg_bits;
  logic [PAR_W-1:0]                   w_data_ext;
  logic                               w_par_exp;
  logic                               w_sample;
  logic                               w_start;
  logic                               w_shift;
  logic                               w_par_sample;
  logic                               w_complete;
  logic                               w_ferr;
  logic                               w_push;
`ifdef FWUART_RX_BREAK_DETECT_EN
  logic                               r_par_bit;
  logic                               w_break;
`endif

  fwuart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .i_rx   (rx),
    .i_en   (clock_x16),
    .o_rx   (w_rx),
    .o_fall (w_fall)
  );

  assign w_sample = clock_x16 && (r_tick == 4'(SAMPLE_TICK));

  // Clamp the requested data width into the legal range.
  always_comb begin
    w_cfg_bits = cfg_data_bits;
    if ((cfg_data_bits < 4'd5) || (cfg_data_bits > 4'(MAX_DATA_BITS))) begin
      w_cfg_bits = 4'(MAX_DATA_BITS);
    end else begin
      w_cfg_bits = cfg_data_bits;
    end
  end

  // Zero-extend the shift register for the shared parity helper.
  always_comb begin
    w_data_ext                      = '0;
    w_data_ext[MAX_DATA_BITS-1:0]   = r_data;
    w_par_exp                       = parity_calc(w_data_ext, r_cfg_bits, r_cfg_par_odd);
  end

  // Frame state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus one-cycle datapath actions for each sample point.
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_par_sample = 1'b0;
    w_complete   = 1'b0;
    w_ferr       = 1'b0;
`ifdef FWUART_RX_BREAK_DETECT_EN
    w_break      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_start     = 1'b1;
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_sample) begin
          if (w_rx) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_sample) begin
          w_shift = 1'b1;
          if (r_bit_cnt == (r_cfg_bits - 4'd1)) begin
            if (r_cfg_par_en) begin
              w_state_nxt = ST_PARITY;
            end else begin
              w_state_nxt = ST_STOP1;
            end
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_sample) begin
          w_par_sample = 1'b1;
          w_state_nxt  = ST_STOP1;
        end else begin
          w_state_nxt  = ST_PARITY;
        end
      end
      ST_STOP1: begin
        if (w_sample) begin
          if (!w_rx) begin
            w_complete  = 1'b1;
            w_ferr      = 1'b1;
            w_state_nxt = ST_WAIT_IDLE;
`ifdef FWUART_RX_BREAK_DETECT_EN
            if ((r_data == '0) && !r_par_bit) begin
              w_break = 1'b1;
              w_ferr  = 1'b0;
            end else begin
              w_break = 1'b0;
            end
`endif
          end else if (r_cfg_stop2) begin
            w_state_nxt = ST_STOP2;
          end else begin
            w_complete  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_STOP1;
        end
      end
      ST_STOP2: begin
        if (w_sample) begin
          w_complete = 1'b1;
          if (!w_rx) begin
            w_ferr      = 1'b1;
            w_state_nxt = ST_WAIT_IDLE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_STOP2;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_rx) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef FWUART_RX_BREAK_DETECT_EN
  assign w_push = w_complete && !w_break;
`else
  assign w_push = w_complete;
`endif

  // Oversampling tick counter, restarted at the detected start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick <= '0;
    end else if (w_start) begin
      r_tick <= '0;
    end else if (clock_x16) begin
      r_tick <= r_tick + 4'd1;
    end else begin
      r_tick <= r_tick;
    end
  end

  // Frame datapath: latch config at start, shift data bits, check parity.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cfg_bits    <= 4'd0;
      r_cfg_par_en  <= 1'b0;
      r_cfg_par_odd <= 1'b0;
      r_cfg_stop2   <= 1'b0;
      r_data        <= '0;
      r_bit_cnt     <= 4'd0;
      r_par_err     <= 1'b0;
`ifdef FWUART_RX_BREAK_DETECT_EN
      r_par_bit     <= 1'b0;
`endif
    end else if (w_start) begin
      r_cfg_bits    <= w_cfg_bits;
      r_cfg_par_en  <= cfg_parity_en;
      r_cfg_par_odd <= cfg_parity_odd;
      r_cfg_stop2   <= cfg_stop2;
      r_data        <= '0;
      r_bit_cnt     <= 4'd0;
      r_par_err     <= 1'b0;
`ifdef FWUART_RX_BREAK_DETECT_EN
      r_par_bit     <= 1'b0;
`endif
    end else begin
      if (w_shift) begin
        for (int b = 0; b < MAX_DATA_BITS; b++) begin
          if (r_bit_cnt == 4'(b)) begin
            r_data[b] <= w_rx;
          end
        end
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_par_sample) begin
        r_par_err <= (w_rx != w_par_exp);
`ifdef FWUART_RX_BREAK_DETECT_EN
        r_par_bit <= w_rx;
`endif
      end
    end
  end

  // Output register, handshake and error pulses; a full register drops the
  // new character and reports only an overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_dat       <= '0;
      i_valid     <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= (w_state_nxt != ST_IDLE);
      if (w_push && (!i_valid || i_ready)) begin
        i_dat       <= r_data;
        i_valid     <= 1'b1;
        parity_err  <= r_par_err;
        framing_err <= w_ferr;
      end else if (w_push) begin
        overrun_err <= 1'b1;
      end else if (i_valid && i_ready) begin
        i_valid <= 1'b0;
      end else begin
        i_valid <= i_valid;
      end
    end
  end

`ifdef FWUART_RX_BREAK_DETECT_EN
  // One pulse per detected line break.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      break_det <= 1'b0;
    end else begin
      break_det <= w_complete && w_break;
    end
  end
`endif

endmodule
